// File: rtl/ksa_pkg.sv
// Shared types and helpers for the parameterised RC4 key-scheduling engine.
package ksa_pkg;

    localparam int unsigned N_W_DEF      = 8;
    localparam int unsigned KEY_LEN_DEF  = 3;
    localparam int unsigned KEY_BITS_MAX = 512;
    localparam int unsigned WORD_MAX     = 64;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD_I,
        RD_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Word k of a big-endian key; word 0 occupies the most significant bits.
    function automatic logic [WORD_MAX-1:0] key_word(
        input logic [KEY_BITS_MAX-1:0] key,
        input int unsigned             k,
        input int unsigned             n_w,
        input int unsigned             key_len
    );
        logic [KEY_BITS_MAX-1:0] sh;
        sh = key >> ((key_len - 1 - k) * n_w);
        return WORD_MAX'(sh) & ((WORD_MAX'(1) << n_w) - WORD_MAX'(1));
    endfunction

endpackage

// File: rtl/ksa_param_key_sel.sv
// Key latch and key-word selector: holds key_q/len_q and a wrapping word index,
// so the scheduling datapath never needs a modulo operation.
module ksa_param_key_sel
    import ksa_pkg::*;
#(
    parameter int unsigned N_W     = N_W_DEF,
    parameter int unsigned KEY_LEN = KEY_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     adv,
    input  logic [KEY_LEN*N_W-1:0]   key,
    input  logic [$clog2(KEY_LEN+1)-1:0] key_len,
    output logic [N_W-1:0]           kword_c
);

    localparam int unsigned LEN_W  = $clog2(KEY_LEN + 1);
    localparam int unsigned KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int unsigned KEY_W  = KEY_LEN * N_W;

    logic [KEY_W-1:0]  key_q;
    logic [LEN_W-1:0]  len_q;
    logic [KIDX_W-1:0] kidx;
    logic [LEN_W-1:0]  len_clamp_c;
    logic [KIDX_W-1:0] kidx_last_c;

    // Zero or oversize lengths fall back to the full key.
    always_comb begin
        len_clamp_c = key_len;
        if (key_len == '0 || key_len > LEN_W'(KEY_LEN)) begin
            len_clamp_c = LEN_W'(KEY_LEN);
        end
        kidx_last_c = KIDX_W'(LEN_W'(len_q - LEN_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q <= '0;
            len_q <= '0;
            kidx  <= '0;
        end else if (load) begin
            key_q <= key;
            len_q <= len_clamp_c;
            kidx  <= '0;
        end else if (adv) begin
            kidx <= (kidx == kidx_last_c) ? '0 : kidx + KIDX_W'(1);
        end
    end

    always_comb begin
        kword_c = '0;
        for (int unsigned k = 0; k < KEY_LEN; k++) begin
            if (kidx == KIDX_W'(k)) begin
                kword_c = N_W'(key_word(KEY_BITS_MAX'(key_q), k, N_W, KEY_LEN));
            end
        end
    end

endmodule

// File: rtl/ksa_param.sv
// RC4 key-scheduling engine driving a single-port sync-read S memory.
// Define KSA_INIT_EN to fill S[i]=i inside the engine before scheduling.
module ksa_param
    import ksa_pkg::*;
#(
    parameter int unsigned N_W     = N_W_DEF,
    parameter int unsigned KEY_LEN = KEY_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         rdy,
    input  logic [KEY_LEN*N_W-1:0]       key,
    input  logic [$clog2(KEY_LEN+1)-1:0] key_len,
    output logic [N_W-1:0]               addr,
    input  logic [N_W-1:0]               rddata,
    output logic [N_W-1:0]               wrdata,
    output logic                         wren
);

    localparam logic [N_W-1:0] I_LAST = '1;

    ksa_state_t     state, state_n;
    logic [N_W-1:0] i, i_n;
    logic [N_W-1:0] j, j_n;
    logic [N_W-1:0] temp, temp_n;
    logic           rdy_n;
    logic [N_W-1:0] jn_c;
    logic [N_W-1:0] kword_c;
    logic           load_c;
    logic           adv_c;

    ksa_param_key_sel #(
        .N_W     (N_W),
        .KEY_LEN (KEY_LEN)
    ) u_key_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_c),
        .adv     (adv_c),
        .key     (key),
        .key_len (key_len),
        .kword_c (kword_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy   <= 1'b1;
            i     <= '0;
            j     <= '0;
            temp  <= '0;
        end else begin
            state <= state_n;
            rdy   <= rdy_n;
            i     <= i_n;
            j     <= j_n;
            temp  <= temp_n;
        end
    end

    always_comb begin
        state_n = state;
        rdy_n   = rdy;
        i_n     = i;
        j_n     = j;
        temp_n  = temp;
        addr    = '0;
        wrdata  = '0;
        wren    = 1'b0;
        load_c  = 1'b0;
        adv_c   = 1'b0;
        jn_c    = j + rddata + kword_c;

        case (state)
            IDLE: begin
                if (en && rdy) begin
                    load_c = 1'b1;
                    i_n    = '0;
                    j_n    = '0;
                    rdy_n  = 1'b0;
`ifdef KSA_INIT_EN
                    state_n = INIT;
`else
                    state_n = RD_I;
`endif
                end
            end
`ifdef KSA_INIT_EN
            INIT: begin
                addr   = i;
                wrdata = i;
                wren   = 1'b1;
                i_n    = i + N_W'(1);
                if (i == I_LAST) begin
                    i_n     = '0;
                    state_n = RD_I;
                end
            end
`endif
            RD_I: begin
                addr    = i;
                state_n = RD_J;
            end
            // rddata holds S[i] here; read S[jn] for the swap.
            RD_J: begin
                addr    = jn_c;
                temp_n  = rddata;
                j_n     = jn_c;
                state_n = WR_I;
            end
            WR_I: begin
                addr    = i;
                wrdata  = rddata;
                wren    = 1'b1;
                state_n = WR_J;
            end
            WR_J: begin
                addr    = j;
                wrdata  = temp;
                wren    = 1'b1;
                i_n     = i + N_W'(1);
                adv_c   = 1'b1;
                state_n = (i == I_LAST) ? DONE : RD_I;
            end
            DONE: begin
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
